// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format codes,
// opcode constants and the output-buffer state encoding.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  // Base-ISA opcodes that are valid but carry no immediate.
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {imm, fmt} decoder, sign-extended to XLEN.
// With IMM_GEN_ILLEGAL_EN defined it also flags unknown/compressed encodings.
import imm_gen_pkg::*;

module imm_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [31:0] imm32;

  // Bits [1:0] are part of the matched opcode, so compressed words fall to default.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
`ifdef IMM_GEN_ILLEGAL_EN
    illegal = 1'b0;
`endif
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      OPC_STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OPC_OP, OPC_OP32, OPC_MISC_MEM, OPC_SYSTEM: ;
      default: begin
`ifdef IMM_GEN_ILLEGAL_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: valid/ready input, registered output plus a
// skid register so in_ready is a flop. Optional out_illegal via IMM_GEN_ILLEGAL_EN.
import imm_gen_pkg::*;

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  buf_state_e       state_q, state_d;
  logic             in_ready_q;
  logic             accept, pop;
  logic             load_new, load_skid, load_from_skid;

  logic [XLEN-1:0]  dec_imm, out_imm_q, skid_imm_q;
  logic [2:0]       dec_fmt, out_fmt_q, skid_fmt_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
`ifdef IMM_GEN_ILLEGAL_EN
  logic             dec_illegal, out_ill_q, skid_ill_q;
`endif

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_new       = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d  = ST_ONE;
        load_new = 1'b1;
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_new = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        state_d        = ST_ONE;
        load_from_skid = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so it never depends on out_ready.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // NOTE: the data registers are reset too, because reset values on the outputs are
  // visible and a cleared skid guarantees nothing stale survives a mid-stream reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm_q  <= '0;
      out_fmt_q  <= FMT_NONE;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_tag_q <= '0;
`ifdef IMM_GEN_ILLEGAL_EN
      out_ill_q  <= 1'b0;
      skid_ill_q <= 1'b0;
`endif
    end else begin
      if (load_new) begin
        out_imm_q <= dec_imm;
        out_fmt_q <= dec_fmt;
        out_tag_q <= in_tag;
`ifdef IMM_GEN_ILLEGAL_EN
        out_ill_q <= dec_illegal;
`endif
      end else if (load_from_skid) begin
        out_imm_q <= skid_imm_q;
        out_fmt_q <= skid_fmt_q;
        out_tag_q <= skid_tag_q;
`ifdef IMM_GEN_ILLEGAL_EN
        out_ill_q <= skid_ill_q;
`endif
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm;
        skid_fmt_q <= dec_fmt;
        skid_tag_q <= in_tag;
`ifdef IMM_GEN_ILLEGAL_EN
        skid_ill_q <= dec_illegal;
`endif
      end
    end
  end

  assign in_ready = in_ready_q;
  assign out_imm  = out_imm_q;
  assign out_fmt  = out_fmt_q;
  assign out_tag  = out_tag_q;
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = out_ill_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// table-driven decode checks plus backpressure and mid-stream reset sequences.
import imm_gen_pkg::*;

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  out_tag;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [7:0]  out_tag64;

`ifdef IMM_GEN_ILLEGAL_EN
  logic        out_illegal, out_illegal64;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
    .out_tag   (out_tag)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .in_instr  (in_instr),
    .in_tag    (in_tag),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .out_imm   (out_imm64),
    .out_fmt   (out_fmt64),
    .out_tag   (out_tag64)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .out_illegal (out_illegal64)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] tag,
                            input logic [31:0] imm, input logic [2:0] fmt);
    check({name, ".valid"}, 64'(out_valid), 64'd1);
    check({name, ".tag"},   64'(out_tag),   64'(tag));
    check({name, ".imm"},   64'(out_imm),   64'(imm));
    check({name, ".fmt"},   64'(out_fmt),   64'(fmt));
  endtask

  initial begin
    vecs[0]  = '{32'hFFC12083, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_I,    1'b0};
    vecs[1]  = '{32'h00512423, 32'h00000008, 64'h00000000_00000008, FMT_S,    1'b0};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, FMT_B,    1'b0};
    vecs[3]  = '{32'h123450B7, 32'h12345000, 64'h00000000_12345000, FMT_U,    1'b0};
    vecs[4]  = '{32'h001000EF, 32'h00000800, 64'h00000000_00000800, FMT_J,    1'b0};
    vecs[5]  = '{32'h7FF00093, 32'h000007FF, 64'h00000000_000007FF, FMT_I,    1'b0};
    vecs[6]  = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, FMT_U,    1'b0};
    vecs[7]  = '{32'h00008067, 32'h00000000, 64'h00000000_00000000, FMT_I,    1'b0};
    vecs[8]  = '{32'h00B50533, 32'h00000000, 64'h00000000_00000000, FMT_NONE, 1'b0};
    vecs[9]  = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, FMT_NONE, 1'b1};
    vecs[10] = '{32'h00004501, 32'h00000000, 64'h00000000_00000000, FMT_NONE, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_imm",   64'(out_imm),   64'd0);
    check("rst.out_fmt",   64'(out_fmt),   64'(FMT_NONE));
    check("rst.out_tag",   64'(out_tag),   64'd0);
    check("rst.imm64",     out_imm64,      64'd0);
    rst = 1'b0;
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream with out_ready=1: one result per cycle, 1-cycle latency.
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 8'(8'h10 + i);
      tick();
      expect_out($sformatf("vec%0d", i), 8'(8'h10 + i), vecs[i].imm32, vecs[i].fmt);
      check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
      check($sformatf("vec%0d.imm64", i), out_imm64, vecs[i].imm64);
      check($sformatf("vec%0d.fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt));
`ifdef IMM_GEN_ILLEGAL_EN
      check($sformatf("vec%0d.illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
`endif
    end
    in_valid = 1'b0;
    tick();
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // Backpressure: tags 1,2 fill the buffer, tag 3 must wait.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFC12083;
    in_tag    = 8'd1;
    tick();
    expect_out("bp.t1", 8'd1, 32'hFFFFFFFC, FMT_I);
    check("bp.t1.in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'h00512423;
    in_tag   = 8'd2;
    tick();
    check("bp.full.in_ready", 64'(in_ready), 64'd0);
    expect_out("bp.hold1", 8'd1, 32'hFFFFFFFC, FMT_I);
    in_instr = 32'hFE000CE3;
    in_tag   = 8'd3;
    tick();
    tick();
    check("bp.hold.in_ready", 64'(in_ready), 64'd0);
    expect_out("bp.hold2", 8'd1, 32'hFFFFFFFC, FMT_I);
    out_ready = 1'b1;
    tick();
    expect_out("bp.out2", 8'd2, 32'h00000008, FMT_S);
    check("bp.out2.in_ready", 64'(in_ready), 64'd1);
    tick();
    expect_out("bp.out3", 8'd3, 32'hFFFFFFF8, FMT_B);
    in_valid = 1'b0;
    tick();
    check("bp.empty.out_valid", 64'(out_valid), 64'd0);

    // Reset while FULL discards both entries; nothing stale follows.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h001000EF;
    in_tag    = 8'd4;
    tick();
    in_tag = 8'd5;
    tick();
    check("rstfull.in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check("rstfull.out_valid", 64'(out_valid), 64'd0);
    check("rstfull.out_tag",   64'(out_tag),   64'd0);
    rst = 1'b0;
    check("rstfull.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h123450B7;
    in_tag    = 8'd6;
    tick();
    expect_out("rstfull.new", 8'd6, 32'h12345000, FMT_U);
    check("rstfull.new.imm64", out_imm64, 64'h00000000_12345000);
    in_valid = 1'b0;
    tick();
    check("rstfull.nostale", 64'(out_valid), 64'd0);
    check("rstfull.nostale64", 64'(out_valid64), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
